// File: rtl/stm_event_emitter.sv
// ----------------------------------------------------------------------------
// stm_event_emitter
// ----------------------------------------------------------------------------
// Transmit side of the per-core STM software-trace port. The block watches a
// core's retire/writeback trace and keeps a shadow copy of GPR r3. Each retired
// "l.nop K" with K != 0 becomes an event {id = K, value = r3, timestamp}. The
// events are queued in a small FIFO and handed to the debug interconnect over a
// valid/ready handshake.
//
// Optional feature macro: STM_EMITTER_TIMESTAMP_EN
//   defined     -> a free-running timestamp counter is built and each event
//                  carries the counter value of the cycle it was detected in.
//   not defined -> no counter and no timestamp storage; out_timestamp is 0.
//
// Ports
//   clk            system clock
//   rst            synchronous reset, active high
//   trace_enable   one instruction retires this cycle
//   trace_insn     retired instruction word
//   trace_wben     retiring instruction writes a GPR
//   trace_wbreg    GPR index written
//   trace_wbdata   GPR write data
//   out_valid      FIFO head holds an event
//   out_ready      consumer accepts the head this cycle
//   out_id         event id K
//   out_value      r3 at the time of the l.nop
//   out_timestamp  timestamp at retire of the l.nop (0 when feature is off)
//   lost_count     events dropped on a full FIFO, saturating
//
// All outputs come straight from registers. The head registers are loaded
// with the entry that becomes the head after each edge, so the event is
// visible one cycle after detection, even when the FIFO was empty.
// ----------------------------------------------------------------------------
module stm_event_emitter #(
    parameter int FIFO_DEPTH = 4,
    parameter int TS_WIDTH   = 32,
    parameter int LOST_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trace_enable,
    input  logic [31:0]           trace_insn,
    input  logic                  trace_wben,
    input  logic [4:0]            trace_wbreg,
    input  logic [31:0]           trace_wbdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_id,
    output logic [31:0]           out_value,
    output logic [TS_WIDTH-1:0]   out_timestamp,
    output logic [LOST_WIDTH-1:0] lost_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [15:0]           NOP_OPCODE = 16'h1500;
    localparam logic [4:0]            R3_INDEX   = 5'd3;
    localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]      CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_FULL   = CNT_W'(FIFO_DEPTH);
    localparam logic [LOST_WIDTH-1:0] LOST_ONE   = LOST_WIDTH'(1'b1);
    localparam logic [LOST_WIDTH-1:0] LOST_MAX   = {LOST_WIDTH{1'b1}};

    // An "l.nop K" with a non-zero K is a software trace event; K = 0 is a plain nop.
    function automatic logic is_event(input logic en, input logic [31:0] insn);
        return en & (insn[31:16] == NOP_OPCODE) & (insn[15:0] != 16'h0000);
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [LOST_WIDTH-1:0] sat_inc(input logic [LOST_WIDTH-1:0] v);
        return (v == LOST_MAX) ? v : (v + LOST_ONE);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]           r3_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic [LOST_WIDTH-1:0] lost_r;
    logic                  out_valid_r;
    logic [15:0]           out_id_r;
    logic [31:0]           out_value_r;
    logic [15:0]           mem_id_r  [FIFO_DEPTH];
    logic [31:0]           mem_val_r [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Per-cycle decode
    // ------------------------------------------------------------------
    logic                  wr_r3_s;
    logic                  detect_s;
    logic [31:0]           ev_value_s;
    logic                  pop_s;
    logic                  full_s;
    logic                  push_s;
    logic                  drop_s;
    logic [PTR_W-1:0]      rd_ptr_nxt_s;
    logic [PTR_W-1:0]      wr_ptr_nxt_s;
    logic [CNT_W-1:0]      count_nxt_s;
    logic [CNT_W-1:0]      remain_s;
    logic [LOST_WIDTH-1:0] lost_nxt_s;
    logic [15:0]           head_id_nxt_s;
    logic [31:0]           head_val_nxt_s;

    assign wr_r3_s    = trace_enable & trace_wben & (trace_wbreg == R3_INDEX);
    assign detect_s   = is_event(trace_enable, trace_insn);
    // A write to r3 retiring alongside the l.nop must be seen by the event.
    assign ev_value_s = wr_r3_s ? trace_wbdata : r3_r;
    assign pop_s      = out_valid_r & out_ready;
    assign full_s     = (count_r == CNT_FULL);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_s     = detect_s & (~full_s | pop_s);
    assign drop_s     = detect_s & full_s & ~pop_s;

    // Pointer, occupancy and drop-counter next state.
    always_comb begin
        rd_ptr_nxt_s = rd_ptr_r;
        wr_ptr_nxt_s = wr_ptr_r;
        count_nxt_s  = count_r;
        remain_s     = count_r;
        lost_nxt_s   = lost_r;

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            remain_s     = count_r - CNT_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
            remain_s     = count_r;
        end

        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase

        if (drop_s) begin
            lost_nxt_s = sat_inc(lost_r);
        end else begin
            lost_nxt_s = lost_r;
        end
    end

    // Head selection for the output registers: the oldest entry left after
    // the pop, or the incoming event if nothing else remains; hold otherwise.
    always_comb begin
        head_id_nxt_s  = out_id_r;
        head_val_nxt_s = out_value_r;
        if (remain_s != CNT_ZERO) begin
            head_id_nxt_s  = mem_id_r[rd_ptr_nxt_s];
            head_val_nxt_s = mem_val_r[rd_ptr_nxt_s];
        end else if (push_s) begin
            head_id_nxt_s  = trace_insn[15:0];
            head_val_nxt_s = ev_value_s;
        end else begin
            head_id_nxt_s  = out_id_r;
            head_val_nxt_s = out_value_r;
        end
    end

    // Control state, shadow r3 and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r3_r        <= 32'h0000_0000;
            rd_ptr_r    <= {PTR_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= CNT_ZERO;
            lost_r      <= {LOST_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_id_r    <= 16'h0000;
            out_value_r <= 32'h0000_0000;
        end else begin
            if (wr_r3_s) begin
                r3_r <= trace_wbdata;
            end
            rd_ptr_r    <= rd_ptr_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            count_r     <= count_nxt_s;
            lost_r      <= lost_nxt_s;
            out_valid_r <= (count_nxt_s != CNT_ZERO);
            out_id_r    <= head_id_nxt_s;
            out_value_r <= head_val_nxt_s;
        end
    end

    // Event storage; entries are only read after being written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_id_r[wr_ptr_r]  <= trace_insn[15:0];
            mem_val_r[wr_ptr_r] <= ev_value_s;
        end
    end

`ifdef STM_EMITTER_TIMESTAMP_EN
    localparam logic [TS_WIDTH-1:0] TS_ONE  = TS_WIDTH'(1'b1);
    localparam logic [TS_WIDTH-1:0] TS_ZERO = {TS_WIDTH{1'b0}};

    logic [TS_WIDTH-1:0] ts_r;
    logic [TS_WIDTH-1:0] out_ts_r;
    logic [TS_WIDTH-1:0] mem_ts_r [FIFO_DEPTH];
    logic [TS_WIDTH-1:0] head_ts_nxt_s;

    // Timestamp of the new head, selected the same way as id/value.
    always_comb begin
        head_ts_nxt_s = out_ts_r;
        if (remain_s != CNT_ZERO) begin
            head_ts_nxt_s = mem_ts_r[rd_ptr_nxt_s];
        end else if (push_s) begin
            head_ts_nxt_s = ts_r;
        end else begin
            head_ts_nxt_s = out_ts_r;
        end
    end

    // Free-running timestamp (wraps naturally) and timestamp head register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_r     <= TS_ZERO;
            out_ts_r <= TS_ZERO;
        end else begin
            ts_r     <= ts_r + TS_ONE;
            out_ts_r <= head_ts_nxt_s;
        end
    end

    // Timestamp storage alongside each event entry.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_ts_r[wr_ptr_r] <= ts_r;
        end
    end

    assign out_timestamp = out_ts_r;
`else
    assign out_timestamp = {TS_WIDTH{1'b0}};
`endif

    assign out_valid  = out_valid_r;
    assign out_id     = out_id_r;
    assign out_value  = out_value_r;
    assign lost_count = lost_r;

endmodule

// File: tb/tb_stm_event_emitter.sv
// ----------------------------------------------------------------------------
// tb_stm_event_emitter
// Directed scenarios followed by randomized traffic. A reference model tracks
// shadow r3, the timestamp, FIFO occupancy and the drop counter. Each accepted
// event is pushed into a scoreboard queue. A separate monitor pops that queue
// whenever the DUT hands over an event.
// ----------------------------------------------------------------------------
module tb_stm_event_emitter;

    localparam int DEPTH = 4;
    localparam int TSW   = 32;
    localparam int LW    = 16;
`ifdef STM_EMITTER_TIMESTAMP_EN
    localparam bit TS_ON = 1'b1;
`else
    localparam bit TS_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           trace_enable = 1'b0;
    logic [31:0]    trace_insn = 32'h0;
    logic           trace_wben = 1'b0;
    logic [4:0]     trace_wbreg = 5'd0;
    logic [31:0]    trace_wbdata = 32'h0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [15:0]    out_id;
    logic [31:0]    out_value;
    logic [TSW-1:0] out_timestamp;
    logic [LW-1:0]  lost_count;

    stm_event_emitter #(.FIFO_DEPTH(DEPTH), .TS_WIDTH(TSW), .LOST_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .trace_enable(trace_enable), .trace_insn(trace_insn),
        .trace_wben(trace_wben), .trace_wbreg(trace_wbreg), .trace_wbdata(trace_wbdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_value(out_value), .out_timestamp(out_timestamp),
        .lost_count(lost_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]    id;
        logic [31:0]    val;
        logic [TSW-1:0] ts;
    } ev_t;

    ev_t sb[$];

    // reference model state
    int             m_n    = 0;
    int             m_lost = 0;
    logic [31:0]    m_r3   = 32'h0;
    logic [TSW-1:0] m_ts   = '0;
    bit             m_zero = 1'b1;
    bit             seen_reset = 1'b0;

    // expectations for the cycle currently being driven
    bit             chk_now = 1'b0;
    bit             exp_valid_now;
    int             exp_lost_now;
    bit             exp_zero_now;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and advance the model across the next edge.
    task automatic apply(input bit r, input bit en, input logic [31:0] insn,
                         input bit wben, input logic [4:0] wreg, input logic [31:0] d,
                         input bit rdy);
        bit  pop_m;
        bit  wr3;
        bit  det;
        ev_t ev;
        @(posedge clk);
        #1;
        rst = r; trace_enable = en; trace_insn = insn; trace_wben = wben;
        trace_wbreg = wreg; trace_wbdata = d; out_ready = rdy;

        chk_now       = seen_reset;
        exp_valid_now = (m_n > 0);
        exp_lost_now  = m_lost;
        exp_zero_now  = m_zero;

        if (r) begin
            m_n = 0; m_lost = 0; m_r3 = 32'h0; m_ts = '0; m_zero = 1'b1;
            sb.delete();
            seen_reset = 1'b1;
        end else begin
            pop_m = (m_n > 0) && rdy;
            wr3   = en && wben && (wreg == 5'd3);
            det   = en && (insn[31:16] == 16'h1500) && (insn[15:0] != 16'h0000);
            if (det) begin
                ev.id  = insn[15:0];
                ev.val = wr3 ? d : m_r3;
                ev.ts  = TS_ON ? m_ts : '0;
                if (m_n < DEPTH || pop_m) begin
                    sb.push_back(ev);
                    m_n++;
                    m_zero = 1'b0;
                end else if (m_lost < (2 ** LW) - 1) begin
                    m_lost++;
                end
            end
            if (pop_m) m_n--;
            if (wr3) m_r3 = d;
            m_ts = m_ts + 1;
        end
    endtask

    task automatic idle(input bit rdy);
        apply(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, rdy);
    endtask

    task automatic event_k(input logic [15:0] k, input bit rdy);
        apply(1'b0, 1'b1, {16'h1500, k}, 1'b0, 5'd0, 32'h0, rdy);
    endtask

    // Monitor: sample away from the active edge and compare with the model.
    always @(negedge clk) begin
        ev_t e;
        if (chk_now) begin
            check("out_valid", out_valid, exp_valid_now);
            check("lost_count", lost_count, exp_lost_now);
            if (!TS_ON) check("ts_tied_zero", out_timestamp, 0);
            if (exp_zero_now) begin
                check("idle_id", out_id, 0);
                check("idle_value", out_value, 0);
                check("idle_ts", out_timestamp, 0);
            end
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_event", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("ev_id", out_id, e.id);
                    check("ev_value", out_value, e.val);
                    check("ev_ts", out_timestamp, e.ts);
                end
            end
        end
    end

    initial begin
        int rdy_pct;
        logic [15:0] k;
        logic [31:0] insn;

        // 1: reset, then hold idle
        apply(1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        apply(1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        idle(1'b0); idle(1'b1); idle(1'b1);

        // 2: r3 write then l.nop 4
        apply(1'b0, 1'b1, 32'hE060_0004, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1);
        event_k(16'h0004, 1'b1);
        idle(1'b1); idle(1'b1);

        // 3: plain nop with r4 write, then l.nop 7 uses old r3
        apply(1'b0, 1'b1, 32'h1500_0000, 1'b1, 5'd4, 32'h0000_0005, 1'b1);
        event_k(16'h0007, 1'b1);
        idle(1'b1);

        // 4: same-cycle r3 write bypass
        apply(1'b0, 1'b1, 32'h1500_0009, 1'b1, 5'd3, 32'h1234_5678, 1'b1);
        idle(1'b1); idle(1'b1);

        // 5: overflow with consumer stalled, then full + push + pop
        for (int i = 1; i <= 6; i++) event_k(16'(i), 1'b0);
        idle(1'b0);
        event_k(16'h0010, 1'b1);
        for (int i = 0; i < 6; i++) idle(1'b1);

        // 6: reset with events queued
        for (int i = 0; i < 3; i++) event_k(16'(i + 20), 1'b0);
        apply(1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        idle(1'b1);
        event_k(16'h0030, 1'b1);
        idle(1'b1); idle(1'b1);

        // randomized traffic with varying consumer throughput
        rdy_pct = 70;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) rdy_pct = $urandom_range(0, 100);
            if ($urandom_range(0, 299) == 0) begin
                apply(1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
            end else begin
                if ($urandom_range(0, 9) < 4) begin
                    k    = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom_range(1, 65535));
                    insn = {16'h1500, k};
                end else begin
                    insn = $urandom;
                end
                apply(1'b0, ($urandom_range(0, 9) < 8), insn, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 1) == 1) ? 5'd3 : 5'($urandom_range(0, 31)),
                      $urandom, ($urandom_range(0, 99) < rdy_pct));
            end
        end

        // drain
        for (int i = 0; i < DEPTH + 4; i++) idle(1'b1);
        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
